// File: rtl/vlc_pkg.sv
// Shared definitions for the VLC transmit/receive path: FSM states, framing
// constants, trailer field layout and the CRC-8 next-state function.
package vlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_TRAILER  = 3'd4,
        ST_DROP     = 3'd5
    } vlc_state_t;

    localparam logic [31:0] DEF_PREAMBLE_WORD = 32'hAAAA_AAAA;
    localparam logic [7:0]  DEF_SFD           = 8'hD5;
    localparam logic [7:0]  DEF_EOF_MARK      = 8'h7E;
    localparam logic [7:0]  CRC8_POLY         = 8'h07;

    // Trailer layout: {mark[31:24], trunc[23], count[22:8], crc[7:0]}
    localparam int TRL_MARK_LSB  = 24;
    localparam int TRL_TRUNC_BIT = 23;
    localparam int TRL_COUNT_LSB = 8;
    localparam int TRL_COUNT_W   = 15;
    localparam int TRL_CRC_LSB   = 0;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] pack_trailer(input logic [7:0]  mark,
                                                 input logic        trunc,
                                                 input logic [14:0] count,
                                                 input logic [7:0]  crc);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[TRL_MARK_LSB +: 8]            = mark;
        w[TRL_TRUNC_BIT]                = trunc;
        w[TRL_COUNT_LSB +: TRL_COUNT_W] = count;
        w[TRL_CRC_LSB +: 8]             = crc;
        return w;
    endfunction

endpackage

// File: rtl/vlc_crc8.sv
// Byte-wide CRC-8 (poly 0x07, MSB first) next-state function, shared with the
// receiver so both ends agree on the checksum.
module vlc_crc8
    import vlc_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    assign o_crc = crc8_byte(i_crc, i_data);

endmodule

// File: rtl/vlc_frame_packer.sv
// Builds byte-stream payload frames into 32-bit FIFO words
// (preamble, header, payload, trailer) for the async TX FIFO.
module vlc_frame_packer
    import vlc_pkg::*;
#(
    parameter logic [31:0] PREAMBLE_WORD  = DEF_PREAMBLE_WORD,
    parameter int          PREAMBLE_WORDS = 2,
    parameter logic [7:0]  SFD            = DEF_SFD,
    parameter logic [7:0]  EOF_MARK       = DEF_EOF_MARK,
    parameter int          MAX_BYTES      = 1024
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] wr_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_WORDS - 1);
    localparam logic [14:0] MAX_CNT  = 15'(MAX_BYTES);

    vlc_state_t  r_state;
    logic [31:0] r_word;
    logic        r_pending;
    logic [7:0]  r_seq;
    logic [7:0]  r_crc;
    logic [14:0] r_count;
    logic [1:0]  r_lane;
    logic [3:0]  r_pre_cnt;
    logic        r_trunc;
    logic        r_ended;

    vlc_state_t  w_state_nxt;
    logic [31:0] w_word_nxt;
    logic        w_pending_nxt;
    logic [7:0]  w_seq_nxt;
    logic [7:0]  w_crc_nxt;
    logic [14:0] w_count_nxt;
    logic [1:0]  w_lane_nxt;
    logic [3:0]  w_pre_cnt_nxt;
    logic        w_trunc_nxt;
    logic        w_ended_nxt;

    logic        w_write;
    logic [7:0]  w_crc_upd;
    logic [14:0] w_count_inc;
    logic        w_hit_max;

    vlc_crc8 u_crc8 (
        .i_crc  (r_crc),
        .i_data (s_data),
        .o_crc  (w_crc_upd)
    );

    assign w_write     = r_pending & ~fifo_full;
    assign w_count_inc = r_count + 15'd1;
    assign w_hit_max   = (w_count_inc == MAX_CNT);

    assign wr_data    = r_word;
    assign fifo_wr_en = w_write;
    assign busy       = (r_state != ST_IDLE);
    assign s_ready    = ((r_state == ST_PAYLOAD) & ~r_pending) | (r_state == ST_DROP);
    assign frame_done = (r_state == ST_TRAILER) & w_write;

    // Next-state and datapath update for the framing FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_pending_nxt = r_pending;
        w_seq_nxt     = r_seq;
        w_crc_nxt     = r_crc;
        w_count_nxt   = r_count;
        w_lane_nxt    = r_lane;
        w_pre_cnt_nxt = r_pre_cnt;
        w_trunc_nxt   = r_trunc;
        w_ended_nxt   = r_ended;

        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_word_nxt    = PREAMBLE_WORD;
                    w_pending_nxt = 1'b1;
                    w_pre_cnt_nxt = 4'd0;
                    w_state_nxt   = ST_PREAMBLE;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (w_write) begin
                    if (r_pre_cnt == PRE_LAST) begin
                        w_word_nxt  = {SFD, r_seq, 16'h0000};
                        w_state_nxt = ST_HEADER;
                    end else begin
                        w_pre_cnt_nxt = r_pre_cnt + 4'd1;
                    end
                end else begin
                    w_state_nxt = ST_PREAMBLE;
                end
            end

            ST_HEADER: begin
                if (w_write) begin
                    w_pending_nxt = 1'b0;
                    w_word_nxt    = 32'h0000_0000;
                    w_lane_nxt    = 2'd0;
                    w_state_nxt   = ST_PAYLOAD;
                end else begin
                    w_state_nxt   = ST_HEADER;
                end
            end

            ST_PAYLOAD: begin
                if (r_pending) begin
                    if (w_write && r_ended) begin
                        // count and crc are final once the last byte was taken
                        w_word_nxt  = pack_trailer(EOF_MARK, r_trunc, r_count, r_crc);
                        w_state_nxt = ST_TRAILER;
                    end else if (w_write) begin
                        w_pending_nxt = 1'b0;
                        w_word_nxt    = 32'h0000_0000;
                        w_lane_nxt    = 2'd0;
                    end else begin
                        w_pending_nxt = 1'b1;
                    end
                end else if (s_valid) begin
                    case (r_lane)
                        2'd0:    w_word_nxt[31:24] = s_data;
                        2'd1:    w_word_nxt[23:16] = s_data;
                        2'd2:    w_word_nxt[15:8]  = s_data;
                        default: w_word_nxt[7:0]   = s_data;
                    endcase
                    w_lane_nxt  = r_lane + 2'd1;
                    w_crc_nxt   = w_crc_upd;
                    w_count_nxt = w_count_inc;
                    if ((r_lane == 2'd3) || s_last || w_hit_max) begin
                        w_pending_nxt = 1'b1;
                        w_ended_nxt   = s_last | w_hit_max;
                        w_trunc_nxt   = w_hit_max & ~s_last;
                    end else begin
                        w_pending_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end

            ST_TRAILER: begin
                if (w_write) begin
                    w_pending_nxt = 1'b0;
                    w_seq_nxt     = r_seq + 8'd1;
                    w_crc_nxt     = 8'h00;
                    w_count_nxt   = 15'd0;
                    w_lane_nxt    = 2'd0;
                    w_trunc_nxt   = 1'b0;
                    w_ended_nxt   = 1'b0;
                    w_state_nxt   = r_trunc ? ST_DROP : ST_IDLE;
                end else begin
                    w_state_nxt   = ST_TRAILER;
                end
            end

            ST_DROP: begin
                if (s_valid && s_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_word    <= 32'h0000_0000;
            r_pending <= 1'b0;
            r_seq     <= 8'h00;
            r_crc     <= 8'h00;
            r_count   <= 15'd0;
            r_lane    <= 2'd0;
            r_pre_cnt <= 4'd0;
            r_trunc   <= 1'b0;
            r_ended   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_pending <= w_pending_nxt;
            r_seq     <= w_seq_nxt;
            r_crc     <= w_crc_nxt;
            r_count   <= w_count_nxt;
            r_lane    <= w_lane_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_trunc   <= w_trunc_nxt;
            r_ended   <= w_ended_nxt;
        end
    end

endmodule

// File: tb/tb_vlc_frame_packer.sv
// Directed self-checking bench for vlc_frame_packer: default instance plus a
// MAX_BYTES=8 instance for truncation, selected by sel.
module tb_vlc_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, fifo_full, sel;

    logic        a_ready, a_wr_en, a_busy, a_fd;
    logic        b_ready, b_wr_en, b_busy, b_fd;
    logic [31:0] a_wr_data, b_wr_data;
    logic        ready, wr_en, busy, fd;
    logic [31:0] wr_data;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] wq[$];
    bit          fdq[$];
    int          fd_cnt = 0;
    int          idle_cnt = 0;
    bit          b2b_on = 1'b0;

    always #5 clk = ~clk;

    vlc_frame_packer u_dut (
        .aclk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid & ~sel),
        .s_last(s_last), .s_ready(a_ready), .wr_data(a_wr_data),
        .fifo_wr_en(a_wr_en), .fifo_full(fifo_full), .busy(a_busy), .frame_done(a_fd)
    );

    vlc_frame_packer #(.MAX_BYTES(8)) u_dut8 (
        .aclk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid & sel),
        .s_last(s_last), .s_ready(b_ready), .wr_data(b_wr_data),
        .fifo_wr_en(b_wr_en), .fifo_full(fifo_full), .busy(b_busy), .frame_done(b_fd)
    );

    assign ready   = sel ? b_ready   : a_ready;
    assign wr_en   = sel ? b_wr_en   : a_wr_en;
    assign busy    = sel ? b_busy    : a_busy;
    assign fd      = sel ? b_fd      : a_fd;
    assign wr_data = sel ? b_wr_data : a_wr_data;

    // FIFO-side monitor
    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back(wr_data);
            fdq.push_back(fd);
        end
        if (fd) fd_cnt <= fd_cnt + 1;
        if (b2b_on && !busy) idle_cnt <= idle_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; fifo_full = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        bit done;
        int n;
        done = 1'b0; n = 0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1; s_data = d; s_last = last;
        while (!done && n < 200) begin
            @(negedge clk);
            if (ready) done = 1'b1;
            tick();
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout data=%02h", d);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (wq.size() < n && c < budget) begin
            tick();
            c++;
        end
        tests++;
        if (wq.size() < n) begin
            fails++;
            $display("FAIL wait_words got %0d words, need %0d", wq.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            tests++;
            if (wr_data !== 32'h0) begin
                fails++; $display("FAIL reset_wr_data dut%0d got %h exp 0", s, wr_data);
            end
            tests++;
            if ({wr_en, busy, fd, ready} !== 4'b0000) begin
                fails++; $display("FAIL reset_flags dut%0d got %b exp 0000", s, {wr_en, busy, fd, ready});
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] exp [7];
        logic [31:0] got;
        int          fd0;
        exp = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hD5000000, 32'h31323334,
                32'h35363738, 32'h39000000, 32'h7E0009F4};
        sel = 1'b0; wq.delete(); fdq.delete(); fd0 = fd_cnt;
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8, 0);
        wait_words(7, 100);
        repeat (3) tick();
        tests++;
        if (wq.size() != 7) begin
            fails++; $display("FAIL basic_count got %0d exp 7", wq.size());
        end
        for (int i = 0; i < 7; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL basic_word%0d got %h exp %h", i, got, exp[i]);
            end
        end
        tests++;
        if ((fd_cnt - fd0) != 1 || fdq.size() < 7 || fdq[6] != 1'b1) begin
            fails++; $display("FAIL basic_frame_done pulses %0d exp 1 on trailer", fd_cnt - fd0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [5];
        logic [31:0] got, p_data;
        bit          acc, p_full, p_ready, p_busy;
        int          cyc, fd0;
        exp = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hD5010000, 32'hAB000000, 32'h7E000158};
        sel = 1'b0; wq.delete(); fdq.delete(); fd0 = fd_cnt;
        acc = 1'b0; p_full = 1'b0; p_ready = 1'b0; p_busy = 1'b0; p_data = 32'h0; cyc = 0;
        while (wq.size() < 5 && cyc < 200) begin
            fifo_full = ((cyc / 3) % 2) == 0;
            s_valid = !acc; s_data = 8'hAB; s_last = 1'b1;
            @(negedge clk);
            if (p_full && !p_ready && p_busy) begin
                tests++;
                if (wr_data !== p_data) begin
                    fails++; $display("FAIL bp_hold cyc%0d got %h exp %h", cyc, wr_data, p_data);
                end
            end
            p_full = fifo_full; p_ready = ready; p_busy = busy; p_data = wr_data;
            if (s_valid && ready) acc = 1'b1;
            tick();
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0; fifo_full = 1'b0;
        repeat (4) tick();
        tests++;
        if (wq.size() != 5) begin
            fails++; $display("FAIL bp_count got %0d exp 5", wq.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL bp_word%0d got %h exp %h", i, got, exp[i]);
            end
        end
        tests++;
        if ((fd_cnt - fd0) != 1) begin
            fails++; $display("FAIL bp_frame_done pulses %0d exp 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_trunc();
        logic [31:0] exp [6];
        logic [31:0] got;
        logic [7:0]  crc;
        crc = 8'h00;
        for (int i = 1; i <= 8; i++) crc = crc_step(crc, 8'(i));
        exp = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hD5000000, 32'h01020304,
                32'h05060708, {8'h7E, 1'b1, 15'd8, crc}};
        sel = 1'b1; wq.delete(); fdq.delete();
        for (int i = 1; i <= 11; i++) send_byte(8'(i), i == 11, 0);
        repeat (6) tick();
        tests++;
        if (wq.size() != 6) begin
            fails++; $display("FAIL trunc_count got %0d exp 6", wq.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL trunc_word%0d got %h exp %h", i, got, exp[i]);
            end
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL trunc_idle busy got %b exp 0", busy);
        end
        send_byte(8'h55, 1'b1, 0);
        wait_words(11, 100);
        got = (wq.size() > 8) ? {wq[6][31:16], wq[7][15:0]} : 32'hxxxxxxxx;
        tests++;
        if (got !== 32'hAAAAAAAA) begin
            fails++; $display("FAIL trunc_next_preamble got %h exp aaaaaaaa", got);
        end
        got = (wq.size() > 8) ? wq[8] : 32'hxxxxxxxx;
        tests++;
        if (got !== 32'hD5010000) begin
            fails++; $display("FAIL trunc_next_header got %h exp d5010000", got);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp [5];
        logic [31:0] got;
        logic [7:0]  crc;
        sel = 1'b0; wq.delete();
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0, 0);
        tests++;
        if (wr_en !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre wr_en got %b exp 1", wr_en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({wr_en, busy} !== 2'b00) begin
            fails++; $display("FAIL rstmid_drop wr_en,busy got %b exp 00", {wr_en, busy});
        end
        tests++;
        if (wq.size() != 3) begin
            fails++; $display("FAIL rstmid_written got %0d exp 3", wq.size());
        end
        tick();
        rst = 1'b0;
        tick();
        wq.delete();
        crc = crc_step(crc_step(crc_step(8'h00, 8'h41), 8'h42), 8'h43);
        exp = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hD5000000, 32'h41424300,
                {8'h7E, 1'b0, 15'd3, crc}};
        for (int i = 0; i < 3; i++) send_byte(8'h41 + 8'(i), i == 2, 0);
        wait_words(5, 100);
        for (int i = 0; i < 5; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL rstmid_word%0d got %h exp %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp_w;
        logic [7:0]  fb, crc;
        int          i0;
        do_reset();
        sel = 1'b0; wq.delete();
        i0 = idle_cnt;
        b2b_on = 1'b1;
        for (int f = 0; f < 257; f++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(f + b), b == 3, 0);
        end
        b2b_on = 1'b0;
        wait_words(257 * 5, 400);
        for (int f = 0; f < 257; f++) begin
            fb = 8'(f);
            got = (wq.size() > f * 5 + 2) ? wq[f * 5 + 2] : 32'hxxxxxxxx;
            tests++;
            if (got !== {8'hD5, fb, 16'h0000}) begin
                fails++; $display("FAIL b2b_header f%0d got %h exp %h", f, got, {8'hD5, fb, 16'h0000});
            end
            crc = 8'h00;
            for (int b = 0; b < 4; b++) crc = crc_step(crc, 8'(f + b));
            exp_w = {8'h7E, 1'b0, 15'd4, crc};
            got = (wq.size() > f * 5 + 4) ? wq[f * 5 + 4] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp_w) begin
                fails++; $display("FAIL b2b_trailer f%0d got %h exp %h", f, got, exp_w);
            end
        end
        tests++;
        if ((idle_cnt - i0) != 257) begin
            fails++; $display("FAIL b2b_idle_cycles got %0d exp 257", idle_cnt - i0);
        end
    endtask

    task automatic test_gaps();
        int          gaps [9];
        logic [31:0] exp [7];
        logic [31:0] got;
        gaps = '{2, 1, 3, 0, 1, 2, 0, 3, 1};
        exp = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hD5010000, 32'h31323334,
                32'h35363738, 32'h39000000, 32'h7E0009F4};
        sel = 1'b0; wq.delete();
        repeat (2) tick();
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8, gaps[i]);
        wait_words(7, 100);
        for (int i = 2; i < 7; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL gaps_word%0d got %h exp %h", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_trunc();
        test_reset_mid();
        test_back_to_back();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
